// File: rtl/player_ctl_if.sv
// player_ctl_if: key events and vsync into the player controller, registered sprite position out
interface player_ctl_if;
  logic key_valid;
  logic [7:0] key_code;
  logic key_release;
  logic vsync;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic jumping;
  logic pos_valid;
  modport master (output key_valid, key_code, key_release, vsync, input xpos, ypos, jumping, pos_valid);
  modport slave (input key_valid, key_code, key_release, vsync, output xpos, ypos, jumping, pos_valid);
endinterface

// File: rtl/player_ctl.sv
// player_ctl: per-frame sprite position/jump controller; clk, rst, bus (key events + vsync in, xpos/ypos/jumping/pos_valid out)
module player_ctl #(
  parameter int X_INIT = 400,
  parameter int X_MIN = 0,
  parameter int X_MAX = 767,
  parameter int Y_GROUND = 536,
  parameter int STEP = 4,
  parameter int JUMP_STEP = 6,
  parameter int JUMP_FRAMES = 20
) (
  input logic clk,
  input logic rst,
  player_ctl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RISE, FALL} state_t;
  state_t state, state_n;
  logic vsync_d, left_held, right_held, jump_req, tick, jumping_n;
  logic [7:0] rise_cnt, rise_cnt_n;
  logic [12:0] x13, y13;
  logic [11:0] x_n, y_n;
  logic is_make;
  assign tick = bus.vsync & ~vsync_d;
  assign x13 = {1'b0, bus.xpos};
  assign y13 = {1'b0, bus.ypos};
  assign is_make = bus.key_valid & ~bus.key_release;
  assign x_n = (left_held & ~right_held) ? ((x13 < 13'(X_MIN + STEP)) ? 12'(X_MIN) : 12'(x13 - 13'(STEP))) :
               (right_held & ~left_held) ? ((x13 > 13'(X_MAX - STEP)) ? 12'(X_MAX) : 12'(x13 + 13'(STEP))) :
               bus.xpos;
  always_comb begin
    state_n = state;
    y_n = bus.ypos;
    rise_cnt_n = rise_cnt;
    jumping_n = bus.jumping;
    case (state)
      IDLE: if (jump_req) begin
        state_n = RISE;
        rise_cnt_n = '0;
        jumping_n = 1'b1;
      end
      RISE: begin
        y_n = (y13 < 13'(JUMP_STEP)) ? 12'd0 : 12'(y13 - 13'(JUMP_STEP));
        rise_cnt_n = rise_cnt + 8'd1;
        if (rise_cnt == 8'(JUMP_FRAMES - 1)) state_n = FALL;
      end
      FALL: begin
        y_n = (y13 + 13'(JUMP_STEP) >= 13'(Y_GROUND)) ? 12'(Y_GROUND) : 12'(y13 + 13'(JUMP_STEP));
        if (y13 + 13'(JUMP_STEP) >= 13'(Y_GROUND)) begin
          state_n = IDLE;
          jumping_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rise_cnt <= '0;
      vsync_d <= 1'b1;
      left_held <= 1'b0;
      right_held <= 1'b0;
      jump_req <= 1'b0;
      bus.xpos <= 12'(X_INIT);
      bus.ypos <= 12'(Y_GROUND);
      bus.jumping <= 1'b0;
      bus.pos_valid <= 1'b0;
    end else begin
      vsync_d <= bus.vsync;
      bus.pos_valid <= tick;
      if (bus.key_valid && bus.key_code == 8'h1C) left_held <= ~bus.key_release;
      if (bus.key_valid && bus.key_code == 8'h23) right_held <= ~bus.key_release;
      // a space press arriving with the tick survives the tick's clear and triggers on the next frame
      jump_req <= (is_make && bus.key_code == 8'h29) ? 1'b1 : tick ? 1'b0 : jump_req;
      if (tick) begin
        bus.xpos <= x_n;
        bus.ypos <= y_n;
        bus.jumping <= jumping_n;
        state <= state_n;
        rise_cnt <= rise_cnt_n;
      end
    end
  end
endmodule
